// File: rtl/hex_pkg.sv
// Shared definitions for the HEX display message sequencer.
package hex_pkg;

    localparam int HEX_W = 4;
    localparam logic [HEX_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        SCROLL = 2'd2
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and pulses tick_o on the last count.
// When disabled or cleared the count returns to 0, so a fresh enable always
// waits a full DIV cycles before the first tick.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next count: hold at zero unless enabled, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || (cnt_q == LAST)) cnt_d = '0;
        else                                    cnt_d = cnt_q + CW'(1);
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Message sequencer for the six HEX displays: holds a circular digit buffer
// (message followed by blanks), shows a N_HEX-wide window of it and, while
// scrolling, slides the window one position per prescaler tick.
module hex_scroll_ctrl
    import hex_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int STEP_HZ  = 2,
    parameter int N_DIGITS = 8,
    parameter int N_HEX    = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      load_i,
    input  logic [HEX_W*N_DIGITS-1:0] msg_i,
    input  logic                      run_i,
    output logic [HEX_W*N_HEX-1:0]    digit_out_o,
    output logic [$clog2(N_DIGITS+N_HEX)-1:0] pos_o,
    output logic                      wrap_o,
    output logic                      busy_o
);

    localparam int L        = N_DIGITS + N_HEX;
    localparam int PW       = $clog2(L);
    localparam int TICK_DIV = CLK_HZ / STEP_HZ;
    localparam logic [PW-1:0] LAST = PW'(L - 1);
    localparam logic [PW:0]   L_W  = (PW+1)'(L);

    state_e                          state_q, state_d;
    logic [PW-1:0]                   pos_q, pos_d;
    logic                            wrap_q, wrap_d;
    logic [L-1:0][HEX_W-1:0]         buf_q, buf_d;
    logic [N_HEX-1:0][HEX_W-1:0]     dig_q, dig_d;
    logic                            tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == SCROLL),
        .clr_i   (load_i),
        .tick_o  (tick)
    );

    // Buffer capture: message digits first (top nibble = entry 0), then blanks.
    always_comb begin
        buf_d = buf_q;
        if (load_i) begin
            for (int i = 0; i < N_DIGITS; i++)
                buf_d[i] = msg_i[HEX_W*(N_DIGITS-1-i) +: HEX_W];
            for (int i = N_DIGITS; i < L; i++)
                buf_d[i] = BLANK_CODE;
        end
    end

    // FSM next state and window position; load overrides any tick that cycle.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE:    state_d = IDLE;
            SHOW:    if (run_i)  state_d = SCROLL;
            SCROLL:  if (!run_i) state_d = SHOW;
            default: state_d = IDLE;
        endcase
        if (load_i) begin
            state_d = run_i ? SCROLL : SHOW;
            pos_d   = '0;
        end else if (tick) begin
            pos_d  = (pos_q == LAST) ? '0 : pos_q + PW'(1);
            wrap_d = (pos_q == LAST);
        end
    end

    // Window mux from next-state values so outputs track load/tick one edge later.
    // Display g = 0 is HEX5 (top nibble); index wraps by a single subtract.
    for (genvar g = 0; g < N_HEX; g++) begin : g_disp
        logic [PW:0] sum, idx;
        assign sum = {1'b0, pos_d} + (PW+1)'(g);
        assign idx = (sum >= L_W) ? sum - L_W : sum;
        assign dig_d[N_HEX-1-g] = buf_d[idx[PW-1:0]];
    end

    // State, buffer, position and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            buf_q   <= {L{BLANK_CODE}};
            dig_q   <= {N_HEX{BLANK_CODE}};
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            buf_q   <= buf_d;
            dig_q   <= dig_d;
        end
    end

    assign digit_out_o = dig_q;
    assign pos_o       = pos_q;
    assign wrap_o      = wrap_q;
    assign busy_o      = (state_q == SCROLL);

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with TICK_DIV=10, 8 digits, 6 displays.
module tb_hex_scroll_ctrl;

    logic        clk, rst_n, load, run;
    logic [31:0] msg;
    logic [23:0] digit_out;
    logic [3:0]  pos;
    logic        wrap, busy;

    int errors = 0;
    int checks = 0;

    hex_scroll_ctrl #(
        .CLK_HZ(10), .STEP_HZ(1), .N_DIGITS(8), .N_HEX(6)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .load_i      (load),
        .msg_i       (msg),
        .run_i       (run),
        .digit_out_o (digit_out),
        .pos_o       (pos),
        .wrap_o      (wrap),
        .busy_o      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One vector per scroll step: expected window after the tick edge.
    typedef struct {
        logic [3:0]  pos;
        logic [23:0] dig;
        logic        wrap;
    } vec_t;

    vec_t tbl[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Wait one full prescaler period, checking the window is held until the tick.
    task automatic scroll_step(input logic [3:0] prev_pos, input vec_t v);
        repeat (9) step();
        chk("pos_hold", {28'd0, pos}, {28'd0, prev_pos});
        step();
        chk("pos_step", {28'd0, pos}, {28'd0, v.pos});
        chk("dig_step", {8'd0, digit_out}, {8'd0, v.dig});
        chk("wrap_step", {31'd0, wrap}, {31'd0, v.wrap});
    endtask

    initial begin
        // Windows of message 0518_2000 + six blanks, for pos 1..13 then back to 0.
        tbl[0]  = '{4'd1,  24'h518200, 1'b0};
        tbl[1]  = '{4'd2,  24'h182000, 1'b0};
        tbl[2]  = '{4'd3,  24'h82000F, 1'b0};
        tbl[3]  = '{4'd4,  24'h2000FF, 1'b0};
        tbl[4]  = '{4'd5,  24'h000FFF, 1'b0};
        tbl[5]  = '{4'd6,  24'h00FFFF, 1'b0};
        tbl[6]  = '{4'd7,  24'h0FFFFF, 1'b0};
        tbl[7]  = '{4'd8,  24'hFFFFFF, 1'b0};
        tbl[8]  = '{4'd9,  24'hFFFFF0, 1'b0};
        tbl[9]  = '{4'd10, 24'hFFFF05, 1'b0};
        tbl[10] = '{4'd11, 24'hFFF051, 1'b0};
        tbl[11] = '{4'd12, 24'hFF0518, 1'b0};
        tbl[12] = '{4'd13, 24'hF05182, 1'b0};
        tbl[13] = '{4'd0,  24'h051820, 1'b1};

        rst_n = 1'b0; load = 1'b0; run = 1'b0; msg = 32'h0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_dig",  {8'd0, digit_out}, 32'h00FFFFFF);
        chk("rst_pos",  {28'd0, pos}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);

        // Static load.
        msg = 32'h0518_2000; load = 1'b1; run = 1'b0;
        step();
        load = 1'b0;
        chk("show_dig",  {8'd0, digit_out}, 32'h00051820);
        chk("show_pos",  {28'd0, pos}, 32'd0);
        chk("show_busy", {31'd0, busy}, 32'd0);
        repeat (50) step();
        chk("show_hold_dig", {8'd0, digit_out}, 32'h00051820);
        chk("show_hold_pos", {28'd0, pos}, 32'd0);

        // Scroll the full loop; the return to 0 carries the wrap pulse.
        run = 1'b1;
        step();
        chk("scroll_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 14; k++)
            scroll_step((k == 0) ? 4'd0 : tbl[k-1].pos, tbl[k]);
        step();
        chk("wrap_drop", {31'd0, wrap}, 32'd0);
        repeat (8) step();

        // Advance to pos 4, then pause for 100 cycles.
        step();
        chk("pos1", {28'd0, pos}, 32'd1);
        for (int k = 1; k < 4; k++)
            scroll_step(tbl[k-1].pos, tbl[k]);
        run = 1'b0;
        step();
        chk("pause_busy", {31'd0, busy}, 32'd0);
        repeat (100) step();
        chk("pause_pos", {28'd0, pos}, 32'd4);
        chk("pause_dig", {8'd0, digit_out}, 32'h002000FF);
        run = 1'b1;
        step();
        scroll_step(4'd4, tbl[4]);

        // Load on the tick cycle: load wins, no wrap, prescaler restarts.
        repeat (9) step();
        msg = 32'h1234_5678; load = 1'b1;
        step();
        load = 1'b0;
        chk("lt_pos",  {28'd0, pos}, 32'd0);
        chk("lt_wrap", {31'd0, wrap}, 32'd0);
        chk("lt_dig",  {8'd0, digit_out}, 32'h00123456);
        msg = 32'hDEAD_BEEF;
        scroll_step(4'd0, '{4'd1, 24'h234567, 1'b0});

        // Asynchronous reset in mid-cycle while scrolling.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_dig",  {8'd0, digit_out}, 32'h00FFFFFF);
        chk("arst_pos",  {28'd0, pos}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("idle_pos", {28'd0, pos}, 32'd0);
        chk("idle_dig", {8'd0, digit_out}, 32'h00FFFFFF);

        // Load from IDLE with run high goes straight to scrolling.
        msg = 32'h0518_2000; load = 1'b1;
        step();
        load = 1'b0;
        chk("idle_scroll_busy", {31'd0, busy}, 32'd1);
        chk("idle_scroll_dig",  {8'd0, digit_out}, 32'h00051820);
        scroll_step(4'd0, tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
